// File: rtl/univ_shift_reg.sv
// Universal shift register: load, push, rotate and arithmetic shift,
// with a shift counter, empty flag and full-rotation pulse.
module univ_shift_reg #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ENB,
  input  logic [2:0]                 MODO,
  input  logic                       DIR,
  input  logic [WIDTH-1:0]           D,
  input  logic                       S_IN,
  output logic [WIDTH-1:0]           Q,
  output logic                       S_OUT,
  output logic [$clog2(WIDTH+1)-1:0] CNT,
  output logic                       EMPTY,
  output logic                       WRAP
);

  localparam int CW = $clog2(WIDTH+1);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_PUSH  = 3'b010;
  localparam logic [2:0] OP_CYCLE = 3'b011;
  localparam logic [2:0] OP_ARITH = 3'b100;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  logic fill_r;

  // Right shifts fill from S_IN, except ARITH which replicates the sign bit.
  assign fill_r = (MODO == OP_ARITH) ? Q[WIDTH-1] : S_IN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q     <= RESET_VAL;
      S_OUT <= 1'b0;
      CNT   <= CNT_FULL;
      EMPTY <= 1'b1;
      WRAP  <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (ENB) begin
        case (MODO)
          OP_LOAD: begin
            Q     <= D;
            S_OUT <= 1'b0;
            CNT   <= '0;
            EMPTY <= 1'b0;
          end
          OP_PUSH, OP_ARITH: begin
            if (!DIR) begin
              Q     <= {Q[WIDTH-2:0], S_IN};
              S_OUT <= Q[WIDTH-1];
            end else begin
              Q     <= {fill_r, Q[WIDTH-1:1]};
              S_OUT <= Q[0];
            end
            if (CNT != CNT_FULL) CNT <= CNT + 1'b1;
            EMPTY <= (CNT >= CNT_LAST);
          end
          OP_CYCLE: begin
            if (!DIR) begin
              Q     <= {Q[WIDTH-2:0], Q[WIDTH-1]};
              S_OUT <= Q[WIDTH-1];
            end else begin
              Q     <= {Q[0], Q[WIDTH-1:1]};
              S_OUT <= Q[0];
            end
            // A drained register keeps rotating but no longer counts.
            if (CNT != CNT_FULL) begin
              if (CNT == CNT_LAST) begin
                CNT  <= '0;
                WRAP <= 1'b1;
              end else begin
                CNT <= CNT + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
